// File: rtl/sigmoid_pkg.sv
// Shared constants and loader state encoding for the sigmoid table path.
// Imported by the table loader and reusable by the lookup wrapper.
package sigmoid_pkg;

    localparam int SIG_ADDR_WIDTH   = 11;
    localparam int SIG_DATA_WIDTH   = 16;
    localparam int SIG_DEPTH        = 1 << SIG_ADDR_WIDTH;
    localparam int SIG_READ_LATENCY = 2;
    localparam int SIG_SUM_WIDTH    = 32;

    localparam int ST_IDLE_BIT   = 0;
    localparam int ST_LOAD_BIT   = 1;
    localparam int ST_VERIFY_BIT = 2;
    localparam int ST_DONE_BIT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'(1 << ST_IDLE_BIT),
        ST_LOAD   = 4'(1 << ST_LOAD_BIT),
        ST_VERIFY = 4'(1 << ST_VERIFY_BIT),
        ST_DONE   = 4'(1 << ST_DONE_BIT)
    } loader_state_e;

endpackage

// File: rtl/bram_read_tracker.sv
// Follows BRAM reads through the fixed read latency so the consumer knows
// which douta samples are real, and which one belongs to the final address.
module bram_read_tracker #(
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic issue_in,
    input  logic last_in,
    output logic valid_out,
    output logic last_out
);

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q[0] <= issue_in;
            last_q[0]  <= issue_in & last_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign valid_out = valid_q[READ_LATENCY-1];
    assign last_out  = last_q[READ_LATENCY-1];

endmodule

// File: rtl/sigmoid_table_loader.sv
// Fills the sigmoid BRAM from a valid/ready word stream, then reads the whole
// table back and compares sums before declaring the table usable.
module sigmoid_table_loader
    import sigmoid_pkg::*;
#(
    parameter int ADDR_WIDTH   = SIG_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SIG_DATA_WIDTH,
    parameter int READ_LATENCY = SIG_READ_LATENCY,
    parameter int SUM_WIDTH    = SIG_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_valid_in,
    output logic                  s_ready_out,
    output logic                  bram_en_out,
    output logic                  bram_we_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] bram_din_out,
    input  logic [DATA_WIDTH-1:0] bram_dout_in,
    output logic                  busy_out,
    output logic                  ready_out,
    output logic [SUM_WIDTH-1:0]  checksum_out,
    output logic                  mismatch_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    loader_state_e         state_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_active_q;
    logic                  bram_en_q;
    logic                  bram_we_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0] bram_din_q;
    logic [SUM_WIDTH-1:0]  wr_sum_q;
    logic [SUM_WIDTH-1:0]  rd_sum_q;
    logic [SUM_WIDTH-1:0]  checksum_q;
    logic                  ready_q;
    logic                  mismatch_q;

    logic [SUM_WIDTH-1:0]  wr_sum_d;
    logic [SUM_WIDTH-1:0]  rd_sum_d;
    logic                  rd_issue_port;
    logic                  rd_last_port;
    logic                  rd_valid;
    logic                  rd_last;

    assign wr_sum_d = wr_sum_q + SUM_WIDTH'(s_data_in);
    assign rd_sum_d = rd_sum_q + SUM_WIDTH'(bram_dout_in);

    // Qualify from what the BRAM actually sees, so tracker timing matches the port.
    assign rd_issue_port = bram_en_q & ~bram_we_q;
    assign rd_last_port  = (bram_addr_q == LAST_ADDR);

    bram_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .issue_in  (rd_issue_port),
        .last_in   (rd_last_port),
        .valid_out (rd_valid),
        .last_out  (rd_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_active_q <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            wr_sum_q    <= '0;
            rd_sum_q    <= '0;
            checksum_q  <= '0;
            ready_q     <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_q    <= ST_LOAD;
                        wr_addr_q  <= '0;
                        wr_sum_q   <= '0;
                        rd_sum_q   <= '0;
                        mismatch_q <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid_in) begin
                        bram_en_q   <= 1'b1;
                        bram_we_q   <= 1'b1;
                        bram_addr_q <= wr_addr_q;
                        bram_din_q  <= s_data_in;
                        wr_addr_q   <= wr_addr_q + ADDR_ONE;
                        wr_sum_q    <= wr_sum_d;
                        if (wr_addr_q == LAST_ADDR) begin
                            state_q     <= ST_VERIFY;
                            rd_addr_q   <= '0;
                            rd_active_q <= 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (rd_active_q) begin
                        bram_en_q   <= 1'b1;
                        bram_addr_q <= rd_addr_q;
                        rd_addr_q   <= rd_addr_q + ADDR_ONE;
                        if (rd_addr_q == LAST_ADDR) begin
                            rd_active_q <= 1'b0;
                        end
                    end
                    if (rd_valid) begin
                        rd_sum_q <= rd_sum_d;
                        if (rd_last) begin
                            state_q    <= ST_DONE;
                            checksum_q <= wr_sum_q;
                            mismatch_q <= (rd_sum_d != wr_sum_q);
                            ready_q    <= (rd_sum_d == wr_sum_q);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready_out   = (state_q == ST_LOAD);
    assign busy_out      = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign bram_en_out   = bram_en_q;
    assign bram_we_out   = bram_we_q;
    assign bram_addr_out = bram_addr_q;
    assign bram_din_out  = bram_din_q;
    assign ready_out     = ready_q;
    assign checksum_out  = checksum_q;
    assign mismatch_out  = mismatch_q;

endmodule

// File: tb/tb_sigmoid_table_loader.sv
// Randomized bench for the sigmoid table loader: drives loads into a BRAM
// model and checks writes, readback and sums against a plain-arithmetic model.
module tb_sigmoid_table_loader;

    localparam int AW        = 11;
    localparam int DW        = 16;
    localparam int SW        = 32;
    localparam int RL        = 2;
    localparam int DEPTH     = 1 << AW;
    localparam int WORDS_MAX = 2304;
    localparam int CYC_LIMIT = 12000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_in = 1'b0;
    logic [DW-1:0] s_data_in = '0;
    logic          s_valid_in = 1'b0;
    logic          s_ready_out;
    logic          bram_en_out;
    logic          bram_we_out;
    logic [AW-1:0] bram_addr_out;
    logic [DW-1:0] bram_din_out;
    logic [DW-1:0] bram_dout_in = '0;
    logic          busy_out;
    logic          ready_out;
    logic [SW-1:0] checksum_out;
    logic          mismatch_out;

    sigmoid_table_loader #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .SUM_WIDTH    (SW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_in      (start_in),
        .s_data_in     (s_data_in),
        .s_valid_in    (s_valid_in),
        .s_ready_out   (s_ready_out),
        .bram_en_out   (bram_en_out),
        .bram_we_out   (bram_we_out),
        .bram_addr_out (bram_addr_out),
        .bram_din_out  (bram_din_out),
        .bram_dout_in  (bram_dout_in),
        .busy_out      (busy_out),
        .ready_out     (ready_out),
        .checksum_out  (checksum_out),
        .mismatch_out  (mismatch_out)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM: array read into a pipeline register, then an output register.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_pipe = '0;
    bit            corrupt5 = 1'b0;

    always @(posedge clk) begin
        if (bram_en_out) begin
            if (bram_we_out) mem[bram_addr_out] <= bram_din_out;
            rd_pipe <= mem[bram_addr_out] ^ ((corrupt5 && bram_addr_out == 11'd5) ? 16'h0001 : 16'h0000);
        end
        bram_dout_in <= rd_pipe;
    end

    logic [DW-1:0] words [WORDS_MAX];
    int n_chk = 0;
    int n_err = 0;
    int wr_cnt, wr_bad, rd_cnt, rd_bad, en_idle_bad;
    int rdy_bad, extra_hits, accepted, cyc_used;
    bit done_ok;
    bit mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bram_en_out && bram_we_out) begin
                if (wr_cnt >= DEPTH || bram_addr_out != 11'(wr_cnt) || bram_din_out != words[wr_cnt]) wr_bad++;
                wr_cnt++;
            end else if (bram_en_out) begin
                if (rd_cnt >= DEPTH || bram_addr_out != 11'(rd_cnt)) rd_bad++;
                rd_cnt++;
            end
            if (!busy_out && bram_en_out) en_idle_bad++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(input bit flip5);
        logic [31:0] s;
        logic [15:0] w;
        s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w = words[i];
            if (flip5 && i == 5) w = w ^ 16'h0001;
            s = s + 32'(w);
        end
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl"}, 64'({s_ready_out, bram_en_out, bram_we_out, busy_out, ready_out, mismatch_out}), 64'(0));
        check_eq({tag, "_addr_din"}, 64'({bram_addr_out, bram_din_out}), 64'(0));
        check_eq({tag, "_checksum"}, 64'(checksum_out), 64'(0));
    endtask

    task automatic run_load(input int n_offer, input int vmode, input bit spurious, input int abort_after);
        int idx;
        bit seen_busy;
        idx = 0; seen_busy = 0; extra_hits = 0; rdy_bad = 0; done_ok = 0;
        wr_cnt = 0; wr_bad = 0; rd_cnt = 0; rd_bad = 0; en_idle_bad = 0;
        mon_on = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        cyc_used = 1;
        while (cyc_used < CYC_LIMIT) begin
            if (busy_out) seen_busy = 1;
            else if (seen_busy) begin
                done_ok = 1;
                break;
            end
            if (busy_out && ready_out) rdy_bad++;
            if (abort_after > 0 && idx >= abort_after) break;
            s_valid_in = (idx < n_offer) &&
                         (vmode == 0 || (vmode == 1 && cyc_used % 3 == 0) ||
                          (vmode == 2 && $urandom_range(0, 1) == 1));
            s_data_in  = (idx < n_offer) ? words[idx] : 16'h0000;
            start_in   = spurious && (cyc_used == 500 || cyc_used == 2100);
            if (s_valid_in && s_ready_out) begin
                if (idx >= DEPTH) extra_hits++;
                idx++;
            end
            @(negedge clk);
            cyc_used++;
        end
        s_valid_in = 1'b0;
        start_in   = 1'b0;
        accepted   = idx;
    endtask

    task automatic check_load(input string tag, input bit flip5, input bit use_const,
                              input logic [31:0] const_sum, input bit start_at_done);
        logic [31:0] wsum;
        logic [31:0] rsum;
        bit exp_mm;
        wsum   = model_sum(1'b0);
        rsum   = model_sum(flip5);
        exp_mm = (wsum != rsum);
        $display("load %s: cycles=%0d accepted=%0d writes=%0d reads=%0d checksum=0x%08h ready=%0d mismatch=%0d",
                 tag, cyc_used, accepted, wr_cnt, rd_cnt, checksum_out, ready_out, mismatch_out);
        check_eq({tag, "_done"}, 64'(done_ok), 64'(1));
        check_eq({tag, "_accepted"}, 64'(accepted), 64'(DEPTH));
        check_eq({tag, "_extra_accepts"}, 64'(extra_hits), 64'(0));
        check_eq({tag, "_writes"}, 64'(wr_cnt), 64'(DEPTH));
        check_eq({tag, "_write_order"}, 64'(wr_bad), 64'(0));
        check_eq({tag, "_reads"}, 64'(rd_cnt), 64'(DEPTH));
        check_eq({tag, "_read_order"}, 64'(rd_bad), 64'(0));
        check_eq({tag, "_ready_while_busy"}, 64'(rdy_bad), 64'(0));
        check_eq({tag, "_en_when_idle"}, 64'(en_idle_bad), 64'(0));
        check_eq({tag, "_checksum"}, 64'(checksum_out), 64'(wsum));
        if (use_const) check_eq({tag, "_checksum_const"}, 64'(checksum_out), 64'(const_sum));
        check_eq({tag, "_mismatch"}, 64'(mismatch_out), 64'(exp_mm));
        check_eq({tag, "_ready"}, 64'(ready_out), 64'(!exp_mm));
        start_in = start_at_done;
        @(negedge clk);
        start_in = 1'b0;
        check_eq({tag, "_hold_checksum"}, 64'(checksum_out), 64'(wsum));
        check_eq({tag, "_hold_ready"}, 64'(ready_out), 64'(!exp_mm));
        check_eq({tag, "_idle_busy"}, 64'(busy_out), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Ramp load: addr == data, full-rate stream.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'(i);
        run_load(DEPTH, 0, 1'b0, 0);
        check_eq("t1_latency_ok", 64'(cyc_used <= 2 * DEPTH + RL + 4), 64'(1));
        check_load("t1_ramp", 1'b0, 1'b1, 32'h001F_FC00, 1'b0);

        // Throttled constant stream.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'h8000;
        run_load(DEPTH, 1, 1'b0, 0);
        check_load("t2_throttled", 1'b0, 1'b1, 32'h0400_0000, 1'b0);

        // Corrupted readback of address 5.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'($urandom);
        corrupt5 = 1'b1;
        run_load(DEPTH, 2, 1'b0, 0);
        check_load("t3_corrupt", 1'b1, 1'b0, 32'h0, 1'b0);
        corrupt5 = 1'b0;

        // Two surplus words plus starts during LOAD, VERIFY and DONE.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'($urandom);
        run_load(DEPTH + 2, 0, 1'b1, 0);
        check_load("t4_extra", 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset part-way through a load, then a clean ramp.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'($urandom);
        run_load(DEPTH, 0, 1'b0, 1000);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_partial_writes", 64'(wr_cnt), 64'(1000));
        check_reset_outputs("t5_reset_a");
        @(negedge clk);
        check_reset_outputs("t5_reset_b");
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'(i);
        run_load(DEPTH, 0, 1'b0, 0);
        check_load("t5_after_reset", 1'b0, 1'b1, 32'h001F_FC00, 1'b0);

        // Random data with random valid gaps.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'($urandom);
        run_load(DEPTH, 2, 1'b0, 0);
        check_load("t7_random", 1'b0, 1'b0, 32'h0, 1'b0);

        // Reload over a good table: ready must drop for the whole reload.
        for (int i = 0; i < WORDS_MAX; i++) words[i] = 16'hFFFF;
        run_load(DEPTH, 0, 1'b0, 0);
        check_load("t6_reload", 1'b0, 1'b1, 32'h07FF_F800, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
